// File: rtl/wr_pntrs_and_full.sv
`default_nettype none
// ============================================================================
//  Module      : wr_pntrs_and_full
//  Description : Write-side pointer, Gray pointer, full flag and fill level of
//                a dual-clock FIFO. Optional almost-full output is enabled by
//                defining the macro WR_ALMOST_FULL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module wr_pntrs_and_full #(
    parameter int DWIDTH = 8,
    parameter int AWIDTH = 3
`ifdef WR_ALMOST_FULL_EN
    ,
    parameter int ALMOST_FULL_LVL = 2**AWIDTH - 2
`endif
) (
    input  logic              wr_clk_i,
    input  logic              aclr_i,
    input  logic              wr_req_i,
    input  logic [AWIDTH:0]   rd_pntr_gray_i,
    output logic [AWIDTH-1:0] wr_pntr_o,
    output logic [AWIDTH:0]   wr_pntr_gray_rd_o,
    output logic              wr_full_o,
    output logic [AWIDTH:0]   wr_usedw_o
`ifdef WR_ALMOST_FULL_EN
    ,
    output logic              wr_almost_full_o
`endif
);

    if (AWIDTH < 2 || DWIDTH < 1) begin : g_param_check
        $error("wr_pntrs_and_full: AWIDTH must be >= 2 and DWIDTH >= 1");
    end

    logic [AWIDTH:0] r_wr_pntr_bin;
    logic [AWIDTH:0] w_wr_pntr_bin_next;
    logic [AWIDTH:0] w_wr_pntr_gray_next;
    logic [AWIDTH:0] w_rd_pntr_bin;
    logic [AWIDTH:0] w_usedw_next;
    logic [AWIDTH:0] w_full_pattern;
    logic            w_wr_en;
    logic            w_full_next;

    assign w_wr_en             = wr_req_i & ~wr_full_o;
    assign w_wr_pntr_bin_next  = r_wr_pntr_bin + {{AWIDTH{1'b0}}, w_wr_en};
    assign w_wr_pntr_gray_next = w_wr_pntr_bin_next ^ (w_wr_pntr_bin_next >> 1);

    // Gray->binary: bit i is the XOR of all Gray bits from the MSB down to i.
    always_comb begin
        w_rd_pntr_bin = '0;
        for (int i = 0; i <= AWIDTH; i++) begin
            w_rd_pntr_bin[i] = ^(rd_pntr_gray_i >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer;
    // in Gray code that is the read pointer with its two MSBs inverted.
    assign w_full_pattern = {~rd_pntr_gray_i[AWIDTH:AWIDTH-1], rd_pntr_gray_i[AWIDTH-2:0]};
    assign w_full_next    = (w_wr_pntr_gray_next == w_full_pattern);
    assign w_usedw_next   = w_wr_pntr_bin_next - w_rd_pntr_bin;

    always_ff @(posedge wr_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            r_wr_pntr_bin     <= '0;
            wr_pntr_gray_rd_o <= '0;
            wr_full_o         <= 1'b0;
            wr_usedw_o        <= '0;
        end else begin
            r_wr_pntr_bin     <= w_wr_pntr_bin_next;
            wr_pntr_gray_rd_o <= w_wr_pntr_gray_next;
            wr_full_o         <= w_full_next;
            wr_usedw_o        <= w_usedw_next;
        end
    end

    assign wr_pntr_o = r_wr_pntr_bin[AWIDTH-1:0];

`ifdef WR_ALMOST_FULL_EN
    localparam logic [AWIDTH:0] C_AF_LVL = (AWIDTH + 1)'(ALMOST_FULL_LVL);

    always_ff @(posedge wr_clk_i or posedge aclr_i) begin
        if (aclr_i) begin
            wr_almost_full_o <= 1'b0;
        end else begin
            wr_almost_full_o <= (w_usedw_next >= C_AF_LVL);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_wr_pntrs_and_full.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wr_pntrs_and_full
//  Description : Scoreboard bench for wr_pntrs_and_full (AWIDTH=3, depth 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wr_pntrs_and_full;

    logic       clk;
    logic       aclr;
    logic       wr_req;
    logic [3:0] rd_gray;
    logic [2:0] dut_ptr;
    logic [3:0] dut_gray;
    logic       dut_full;
    logic [3:0] dut_usedw;
    logic       dut_af;

    int vectors;
    int miscompares;

    typedef struct {
        string      name;
        logic [2:0] ptr;
        logic [3:0] gray;
        logic       full;
        logic [3:0] usedw;
        logic       af;
    } exp_t;

    exp_t exp_q[$];

    logic [3:0] gray_tbl [16] = '{4'd0, 4'd1, 4'd3, 4'd2, 4'd6, 4'd7, 4'd5, 4'd4,
                                  4'd12, 4'd13, 4'd15, 4'd14, 4'd10, 4'd11, 4'd9, 4'd8};

`ifdef WR_ALMOST_FULL_EN
    wr_pntrs_and_full #(.DWIDTH(8), .AWIDTH(3), .ALMOST_FULL_LVL(6)) dut (
        .wr_clk_i          (clk),
        .aclr_i            (aclr),
        .wr_req_i          (wr_req),
        .rd_pntr_gray_i    (rd_gray),
        .wr_pntr_o         (dut_ptr),
        .wr_pntr_gray_rd_o (dut_gray),
        .wr_full_o         (dut_full),
        .wr_usedw_o        (dut_usedw),
        .wr_almost_full_o  (dut_af)
    );
`else
    wr_pntrs_and_full #(.DWIDTH(8), .AWIDTH(3)) dut (
        .wr_clk_i          (clk),
        .aclr_i            (aclr),
        .wr_req_i          (wr_req),
        .rd_pntr_gray_i    (rd_gray),
        .wr_pntr_o         (dut_ptr),
        .wr_pntr_gray_rd_o (dut_gray),
        .wr_full_o         (dut_full),
        .wr_usedw_o        (dut_usedw)
    );
    assign dut_af = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic compare(input exp_t e);
        logic ok;
        vectors++;
        ok = (dut_ptr == e.ptr) && (dut_gray == e.gray) &&
             (dut_full == e.full) && (dut_usedw == e.usedw);
`ifdef WR_ALMOST_FULL_EN
        ok = ok && (dut_af == e.af);
`endif
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got ptr=%0d gray=%b full=%b usedw=%0d af=%b, expected ptr=%0d gray=%b full=%b usedw=%0d af=%b",
                     e.name, dut_ptr, dut_gray, dut_full, dut_usedw, dut_af,
                     e.ptr, e.gray, e.full, e.usedw, e.af);
        end
    endtask

    // Drive one cycle of stimulus and queue the state expected after the next edge.
    task automatic step(input logic req, input logic [3:0] rdg, input string name,
                        input logic [2:0] ptr, input logic [3:0] gray, input logic full,
                        input logic [3:0] usedw, input logic af);
        exp_t e;
        @(negedge clk);
        wr_req  = req;
        rd_gray = rdg;
        e.name = name; e.ptr = ptr; e.gray = gray; e.full = full; e.usedw = usedw; e.af = af;
        exp_q.push_back(e);
    endtask

    function automatic exp_t zero_exp(input string name);
        exp_t e;
        e.name = name; e.ptr = '0; e.gray = '0; e.full = 1'b0; e.usedw = '0; e.af = 1'b0;
        return e;
    endfunction

    // Monitor: the DUT presents a new state after every edge.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) compare(exp_q.pop_front());
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        wr_req  = 1'b1;
        rd_gray = 4'd0;
        aclr    = 1'b0;
        #1 aclr = 1'b1;
        #1 compare(zero_exp("reset_init"));
        repeat (2) @(posedge clk);
        @(negedge clk);
        wr_req = 1'b0;
        #1 aclr = 1'b0;

        // Fill 8 slots with the read pointer parked at 0
        for (int k = 1; k <= 8; k++) begin
            logic [3:0] kb;
            kb = 4'(k);
            step(1'b1, 4'd0, "fill", kb[2:0], gray_tbl[k], (k == 8), kb, (k >= 6));
        end

        // Writes while full are dropped
        for (int k = 0; k < 3; k++)
            step(1'b1, 4'd0, "write_when_full", 3'd0, 4'b1100, 1'b1, 4'd8, 1'b1);

        // Read pointer advances by one: full clears, next write refills
        step(1'b0, 4'b0001, "rd_advance", 3'd0, 4'b1100, 1'b0, 4'd7, 1'b1);
        step(1'b1, 4'b0001, "refill", 3'd1, 4'b1101, 1'b1, 4'd8, 1'b1);

        // Asynchronous reset pulsed mid-cycle while a write is requested
        @(negedge clk);
        wr_req = 1'b1;
        #1 aclr = 1'b1;
        #1 compare(zero_exp("async_reset"));
        @(posedge clk);
        #2 compare(zero_exp("reset_hold"));
        @(negedge clk);
        aclr    = 1'b0;
        wr_req  = 1'b0;
        rd_gray = 4'd0;

        // Stream 20 writes with the read pointer trailing by 2, wrapping bin 15 -> 0
        for (int n = 1; n <= 20; n++) begin
            logic [3:0] rdg;
            logic [3:0] nb;
            rdg = (n >= 2) ? gray_tbl[(n - 2) & 15] : 4'd0;
            nb  = 4'(n);
            step(1'b1, rdg, "wrap", nb[2:0], gray_tbl[n & 15], 1'b0,
                 (n == 1) ? 4'd1 : 4'd2, 1'b0);
        end

        @(negedge clk);
        wr_req = 1'b0;
        for (int c = 0; c < 10 && exp_q.size() > 0; c++) @(posedge clk);
        #3;
        if (exp_q.size() > 0) begin
            $display("FAIL drain_timeout: got %0d pending, expected 0 pending", exp_q.size());
            miscompares += exp_q.size();
            vectors     += exp_q.size();
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
